// File: rtl/div_iter_unit_pkg.sv
// Shared state encodings and handshake constants for the iterative divider.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START           = 1'b1;
    localparam logic DIV_STOP            = 1'b0;
    localparam logic DIV_RESULT_READY    = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift {rem, dvd} left, trial-subtract the divisor.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] dvd_next_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so a non-negative trial never sets the top bit.
    assign shifted_rem = {rem_i, dvd_i[WIDTH-1]};
    assign trial       = shifted_rem - {1'b0, divisor_i};
    assign qbit_o      = ~trial[WIDTH];
    assign rem_next_o  = qbit_o ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
    assign dvd_next_o  = {dvd_i[WIDTH-2:0], qbit_o};

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring divider for EX div/divu; returns {remainder, quotient}.
//
//  state       | meaning
//  DIV_FREE    | idle, waiting for start_i without annul_i
//  DIV_BY_ZERO | divisor was zero, result forced to 0
//  DIV_ON      | one quotient bit per cycle, WIDTH cycles
//  DIV_END     | ready_o/result_o valid for one cycle
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    dvd_q, dvd_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic                q_sign_q, q_sign_d;
    logic                r_sign_q, r_sign_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [WIDTH-1:0]    op1_abs, op2_abs;
    logic [WIDTH-1:0]    step_rem, step_dvd;
    logic                step_qbit;
    logic [WIDTH-1:0]    q_fix, r_fix;

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .dvd_i      (dvd_q),
        .divisor_i  (divisor_q),
        .rem_next_o (step_rem),
        .dvd_next_o (step_dvd),
        .qbit_o     (step_qbit)
    );

    // Fix-up is applied to the final step's outputs so the result lands on the END edge.
    assign q_fix = q_sign_q ? (~step_dvd + 1'b1) : step_dvd;
    assign r_fix = r_sign_q ? (~step_rem + 1'b1) : step_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        q_sign_d  = q_sign_q;
        r_sign_d  = r_sign_q;
        result_d  = '0;
        ready_d   = DIV_RESULT_NOT_READY;

        case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    dvd_d     = op1_abs;
                    divisor_d = op2_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    q_sign_d  = op1_neg ^ op2_neg;
                    r_sign_d  = op1_neg;
                    state_d   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                state_d = DIV_END;
                ready_d = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DIV_END;
                        cnt_d    = '0;
                        ready_d  = DIV_RESULT_READY;
                        result_d = {r_fix, q_fix};
                    end
                end
            end
            DIV_END: begin
                state_d = DIV_FREE;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            divisor_q <= '0;
            q_sign_q  <= 1'b0;
            r_sign_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            q_sign_q  <= q_sign_d;
            r_sign_q  <= r_sign_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed corners plus randomized divides.
module tb_div_iter_unit;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int   cyc = 0;
    int   compared = 0;
    int   failed = 0;
    exp_t sb[$];

    div_iter_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Monitor: every cycle either a result is due from the scoreboard or result_o must be 0.
    always @(negedge clk) begin
        exp_t e;
        if (ready_o) begin
            compared++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL unexpected_ready: cycle %0d result %h, no request outstanding", cyc, result_o);
            end else begin
                e = sb.pop_front();
                if (result_o !== e.res || cyc != e.cyc) begin
                    failed++;
                    $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                             result_o, cyc, e.res, e.cyc);
                end
            end
        end else begin
            compared++;
            if (result_o !== 64'd0) begin
                failed++;
                $display("FAIL idle_result: cycle %0d result_o %h while ready_o=0, expected 0", cyc, result_o);
            end
        end
    end

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv);
        bit got;
        exp_t e;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        e.res = expv;
        e.cyc = cyc + ((b == 32'd0) ? 2 : 33);
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
            end else begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
        end
        start_i = 1'b0;
        if (!got) begin
            compared++;
            failed++;
            $display("FAIL timeout: no ready_o for %h / %h, got 0 pulses, expected 1", a, b);
            sb.delete();
        end
    endtask

    initial begin
        int c0;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        resetn       = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(negedge clk);
        compared++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failed++;
            $display("FAIL reset_state: ready_o %b result_o %h, expected 0 and 0", ready_o, result_o);
        end
        resetn = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        do_div(1'b0, 32'h1234_5678, 32'd0, 64'd0);
        do_div(1'b1, 32'h1234_5678, 32'd0, 64'd0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});

        // Annul in cycle 10, restart in cycle 12; restart ready falls in cycle 45.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

        // Reset in cycle 15 of an operation discards it.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 15) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        compared++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failed++;
            $display("FAIL mid_reset: ready_o %b result_o %h, expected 0 and 0", ready_o, result_o);
        end
        resetn  = 1'b1;
        start_i = 1'b0;
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       begin a = 32'h8000_0000; b = $urandom; end
                4:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div(sgn, a, b, ref_div(sgn, a, b));
        end

        repeat (5) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
